// File: rtl/deck_server.sv
// 52-card deck owner: fills, Fisher-Yates shuffles with a free-running LFSR, answers each draw with one card pulse.
// card_valid 2 cycles after an accepted draw (1 card / 3 cycles max); draws while busy/dealing queue one deep, extras dropped.
module deck_server #(
   parameter bit          SHUFFLE_EN = 1'b1,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       draw_card,
   input  logic       shuffle_req,
   output logic [3:0] card_value,
   output logic [1:0] card_suit,
   output logic       card_valid,
   output logic [5:0] cards_left,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_FILL,
      S_PICK,
      S_SWAP,
      S_READY,
      S_DEAL1,
      S_DEAL2
   } state_t;

   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0] TAPS = 16'hB400;

   state_t      state, state_nxt;
   logic [15:0] lfsr;
   logic [5:0]  deck [0:51];
   logic [5:0]  fill_idx, shuf_i, shuf_j, tmp_i, tmp_j, ptr;
   logic        pending;
   logic [5:0]  cand_j, rd_idx;
   logic        cand_ok, deal_start, deal_fire, deal_abort, ready_entry;
   logic [3:0]  map_val;
   logic [1:0]  map_suit;

   assign cand_j  = lfsr[5:0];
   assign cand_ok = (cand_j <= shuf_i);
   assign rd_idx  = deck[ptr];
   assign busy    = (state == S_FILL) || (state == S_PICK) || (state == S_SWAP);

   assign deal_start  = (state == S_READY) && (state_nxt == S_DEAL1);
   assign deal_fire   = (state == S_DEAL1) && !shuffle_req;
   assign deal_abort  = (state == S_DEAL1) && shuffle_req;
   assign ready_entry = ((state == S_FILL) || (state == S_SWAP)) && (state_nxt == S_READY);

   // Card index -> suit/rank without a divider: pick the 13-wide suit band, then offset.
   always_comb begin
      map_suit = 2'd3;
      map_val  = 4'(rd_idx - 6'd39 + 6'd1);
      if (rd_idx < 6'd13) begin
         map_suit = 2'd0;
         map_val  = 4'(rd_idx + 6'd1);
      end else if (rd_idx < 6'd26) begin
         map_suit = 2'd1;
         map_val  = 4'(rd_idx - 6'd13 + 6'd1);
      end else if (rd_idx < 6'd39) begin
         map_suit = 2'd2;
         map_val  = 4'(rd_idx - 6'd26 + 6'd1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FILL:  if (fill_idx == 6'd51) state_nxt = SHUFFLE_EN ? S_PICK : S_READY;
         S_PICK:  if (cand_ok) state_nxt = S_SWAP;
         S_SWAP:  state_nxt = (shuf_i == 6'd1) ? S_READY : S_PICK;
         S_READY: if (draw_card || pending) state_nxt = (cards_left == 6'd0) ? S_FILL : S_DEAL1;
         S_DEAL1: state_nxt = S_DEAL2;
         S_DEAL2: state_nxt = S_READY;
         default: state_nxt = S_FILL;
      endcase
      if (shuffle_req) state_nxt = S_FILL;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FILL;
      else        state <= state_nxt;
   end

   // Deck storage needs no reset: FILL rewrites every entry before any read.
   always_ff @(posedge clk) begin
      if (state == S_FILL) begin
         deck[fill_idx] <= fill_idx;
      end else if (state == S_SWAP) begin
         deck[shuf_i] <= tmp_j;
         deck[shuf_j] <= tmp_i;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr       <= SEED;
         fill_idx   <= 6'd0;
         shuf_i     <= 6'd0;
         shuf_j     <= 6'd0;
         tmp_i      <= 6'd0;
         tmp_j      <= 6'd0;
         ptr        <= 6'd0;
         cards_left <= 6'd0;
         pending    <= 1'b0;
         card_value <= 4'd0;
         card_suit  <= 2'd0;
         card_valid <= 1'b0;
      end else begin
         lfsr       <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
         card_valid <= deal_fire;

         if (deal_start)                    pending <= 1'b0;
         else if (draw_card || deal_abort)  pending <= 1'b1;

         if (state != S_FILL || shuffle_req) fill_idx <= 6'd0;
         else                                fill_idx <= fill_idx + 6'd1;

         if (state == S_FILL)      shuf_i <= 6'd51;
         else if (state == S_SWAP) shuf_i <= shuf_i - 6'd1;

         if (state == S_PICK && cand_ok) begin
            shuf_j <= cand_j;
            tmp_i  <= deck[shuf_i];
            tmp_j  <= deck[cand_j];
         end

         if (shuffle_req) begin
            cards_left <= 6'd0;
         end else if (ready_entry) begin
            cards_left <= 6'd52;
            ptr        <= 6'd0;
         end else if (deal_fire) begin
            cards_left <= cards_left - 6'd1;
            ptr        <= ptr + 6'd1;
            card_value <= map_val;
            card_suit  <= map_suit;
         end
      end
   end

endmodule

// File: tb/tb_deck_server.sv
// Bench for deck_server: fill-order instance checks exact cards/latency; shuffled instance checks uniqueness and reproducibility.
module tb_deck_server;

   typedef struct {
      int due;
      int suit;
      int val;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n0, rst_n1, draw0, draw1, shuf0, shuf1;
   logic [3:0] val0, val1;
   logic [1:0] suit0, suit1;
   logic       vld0, vld1, busy0, busy1;
   logic [5:0] left0, left1;

   int         cyc   = 0;
   int         ntest = 0;
   int         nfail = 0;
   exp_t       sb0[$];
   exp_t       sb1[$];
   logic [5:0] got1[$];
   logic [5:0] runa[$];

   always #5 clk = ~clk;

   deck_server #(.SHUFFLE_EN(1'b0), .LFSR_SEED(16'hACE1)) dut0 (
      .clk(clk), .reset(rst_n0), .draw_card(draw0), .shuffle_req(shuf0),
      .card_value(val0), .card_suit(suit0), .card_valid(vld0),
      .cards_left(left0), .busy(busy0)
   );

   deck_server #(.SHUFFLE_EN(1'b1), .LFSR_SEED(16'hACE1)) dut1 (
      .clk(clk), .reset(rst_n1), .draw_card(draw1), .shuffle_req(shuf1),
      .card_value(val1), .card_suit(suit1), .card_valid(vld1),
      .cards_left(left1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntest++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge and score any card pulse against the queues.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (sb0.size() != 0 && cyc > sb0[0].due) begin
         e = sb0.pop_front();
         chk("dut0_missing_valid", cyc, e.due);
      end
      if (sb1.size() != 0 && cyc > sb1[0].due) begin
         e = sb1.pop_front();
         chk("dut1_missing_valid", cyc, e.due);
      end
      if (vld0 === 1'b1) begin
         if (sb0.size() == 0) chk("dut0_spurious_valid", sb0.size(), 1);
         else begin
            e = sb0.pop_front();
            chk("dut0_valid_cycle", cyc, e.due);
            chk("dut0_suit", suit0, e.suit);
            chk("dut0_value", val0, e.val);
         end
      end
      if (vld1 === 1'b1) begin
         got1.push_back({suit1, val1});
         if (sb1.size() == 0) chk("dut1_spurious_valid", sb1.size(), 1);
         else begin
            e = sb1.pop_front();
            chk("dut1_valid_cycle", cyc, e.due);
         end
      end
   endtask

   task automatic wait_idle(input int which);
      int ok = 0;
      for (int k = 0; k < 3000; k++) begin
         if ((which == 0 ? busy0 : busy1) === 1'b0) begin
            ok = 1;
            break;
         end
         tick();
      end
      chk("busy_fall_timeout", ok, 1);
   endtask

   task automatic push0(input int due, input int idx);
      exp_t e;
      e.due  = due;
      e.suit = idx / 13;
      e.val  = idx % 13 + 1;
      sb0.push_back(e);
   endtask

   task automatic push1(input int due);
      exp_t e;
      e.due  = due;
      e.suit = 0;
      e.val  = 0;
      sb1.push_back(e);
   endtask

   task automatic draw0_card(input int idx);
      draw0 = 1'b1;
      push0(cyc + 2, idx);
      tick();
      draw0 = 1'b0;
      repeat (3) tick();
   endtask

   // Deal the whole deck at the maximum rate with timing fixed relative to reset release.
   task automatic deal_all();
      got1.delete();
      wait_idle(1);
      chk("dut1_left_full", left1, 52);
      for (int k = 0; k < 52; k++) begin
         draw1 = 1'b1;
         push1(cyc + 2);
         tick();
         draw1 = 1'b0;
         repeat (2) tick();
      end
      repeat (4) tick();
      chk("dut1_left_empty", left1, 0);
      chk("dut1_sb_drained", sb1.size(), 0);
      chk("dut1_cards_dealt", got1.size(), 52);
   endtask

   task automatic cmp_runa(input string tag);
      int nmis = 0;
      if (got1.size() != runa.size()) nmis = 99;
      else foreach (got1[i]) if (got1[i] !== runa[i]) nmis++;
      chk(tag, nmis, 0);
   endtask

   task automatic chk_reset1(input string tag);
      chk({tag, "_value"}, val1, 0);
      chk({tag, "_suit"}, suit1, 0);
      chk({tag, "_valid"}, vld1, 0);
      chk({tag, "_left"}, left1, 0);
      chk({tag, "_busy"}, busy1, 1);
   endtask

   initial begin
      logic [51:0] seen;
      rst_n0 = 1'b0; rst_n1 = 1'b0;
      draw0 = 1'b0; draw1 = 1'b0; shuf0 = 1'b0; shuf1 = 1'b0;
      repeat (3) tick();

      chk("dut0_rst_value", val0, 0);
      chk("dut0_rst_suit", suit0, 0);
      chk("dut0_rst_valid", vld0, 0);
      chk("dut0_rst_left", left0, 0);
      chk("dut0_rst_busy", busy0, 1);

      // Fill order: first 14 draws, then on to 20 remaining.
      rst_n0 = 1'b1;
      wait_idle(0);
      chk("dut0_left_full", left0, 52);
      for (int k = 0; k < 14; k++) draw0_card(k);
      chk("dut0_left_after14", left0, 38);
      for (int k = 14; k < 32; k++) draw0_card(k);
      chk("dut0_left_20", left0, 20);

      // Reshuffle and draw in the same cycle: draw becomes pending.
      shuf0 = 1'b1; draw0 = 1'b1;
      tick();
      shuf0 = 1'b0; draw0 = 1'b0;
      chk("dut0_shuf_busy", busy0, 1);
      chk("dut0_shuf_left", left0, 0);
      wait_idle(0);
      push0(cyc + 2, 0);
      repeat (4) tick();
      chk("dut0_shuf_left_after", left0, 51);
      for (int k = 1; k < 52; k++) draw0_card(k);
      chk("dut0_left_empty", left0, 0);

      // Draw on an empty deck.
      draw0 = 1'b1;
      tick();
      draw0 = 1'b0;
      chk("dut0_empty_busy", busy0, 1);
      wait_idle(0);
      push0(cyc + 2, 0);
      repeat (4) tick();
      chk("dut0_empty_left_after", left0, 51);
      chk("dut0_sb_drained", sb0.size(), 0);

      // Shuffled deck: uniqueness of the 52 cards.
      rst_n1 = 1'b1;
      deal_all();
      seen = '0;
      foreach (got1[i]) begin
         logic [5:0] c;
         int ok, idx;
         c  = got1[i];
         ok = (!$isunknown(c) && c[3:0] >= 4'd1 && c[3:0] <= 4'd13) ? 1 : 0;
         if (ok == 1) begin
            idx = int'(c[5:4]) * 13 + int'(c[3:0]) - 1;
            if (seen[idx]) ok = 0;
            seen[idx] = 1'b1;
         end
         chk("dut1_unique_card", ok, 1);
      end
      runa = got1;

      // Clean reset rerun must repeat the sequence.
      rst_n1 = 1'b0;
      repeat (3) tick();
      rst_n1 = 1'b1;
      deal_all();
      cmp_runa("dut1_repeat_clean");

      // Reset in the middle of SHUFFLE.
      rst_n1 = 1'b0;
      tick();
      rst_n1 = 1'b1;
      repeat (70) tick();
      chk("dut1_in_shuffle", busy1, 1);
      rst_n1 = 1'b0;
      #1;
      chk_reset1("dut1_midrst");
      repeat (3) tick();
      chk_reset1("dut1_midrst_hold");
      rst_n1 = 1'b1;
      deal_all();
      cmp_runa("dut1_repeat_midrst");

      // Three draws during SHUFFLE: one card after READY, two dropped.
      rst_n1 = 1'b0;
      tick();
      rst_n1 = 1'b1;
      repeat (60) tick();
      for (int k = 0; k < 3; k++) begin
         chk("dut1_busy_at_draw", busy1, 1);
         draw1 = 1'b1;
         tick();
         draw1 = 1'b0;
         tick();
      end
      wait_idle(1);
      push1(cyc + 2);
      repeat (8) tick();
      chk("dut1_pending_left", left1, 51);
      chk("dut1_pending_drained", sb1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
